// File: rtl/mp3_stereo_pkg.sv
// Shared types and constants for the MP3 joint-stereo datapath.
package mp3_stereo_pkg;

    typedef logic signed [31:0] q2_30_t;

    localparam int unsigned GRANULE_LEN = 576;
    localparam int unsigned IDX_W       = 10;
    localparam int unsigned ACC_W       = 28;

    localparam logic [1:0] MODE_JOINT = 2'b01;
    localparam q2_30_t     MS_K       = 32'sh2d413ccc;
    localparam q2_30_t     SAT_MAX    = 32'sh7fffffff;
    localparam q2_30_t     SAT_MIN    = 32'sh80000000;

    // Stage-1 payload: one accepted sample plus its granule bookkeeping.
    typedef struct packed {
        q2_30_t           l;
        q2_30_t           r;
        logic [IDX_W-1:0] idx;
        logic             gr;
        logic             ms_act;
        logic             err;
    } s1_payload_t;

    // |v| >> 16 for the granule energy accumulators; |-2^32| still fits 33 bits unsigned.
    function automatic logic [ACC_W-1:0] mag_q16(input logic signed [32:0] v);
        logic [32:0] m;
        m = v[32] ? 33'(-v) : 33'(v);
        return ACC_W'(m >> 16);
    endfunction

endpackage

// File: rtl/ms_scale_sat.sv
// Registered 33-bit x sqrt(2)/2 scaler with Q2.30 saturation, or pass-through.
module ms_scale_sat (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        scale,
    input  logic [32:0] x,
    input  logic [31:0] pass,
    output logic [31:0] y
);
    import mp3_stereo_pkg::*;

    logic signed [64:0] prod;
    logic signed [64:0] shifted;
    logic [31:0]        sat_c;

    // Truncating shift (toward -inf), then clamp to the Q2.30 range.
    always_comb begin
        prod    = 65'($signed(x)) * 65'(MS_K);
        shifted = prod >>> 30;
        sat_c   = 32'(shifted);
        if (shifted > 65'(SAT_MAX)) begin
            sat_c = SAT_MAX;
        end else if (shifted < 65'(SAT_MIN)) begin
            sat_c = SAT_MIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y <= '0;
        end else if (en) begin
            y <= scale ? sat_c : pass;
        end
    end

endmodule

// File: rtl/ms_stereo_encoder.sv
// Joint-stereo mid/side encoder: 3-stage pipeline plus per-granule MS recommendation.
module ms_stereo_encoder #(
    parameter int unsigned GRANULE_LEN = mp3_stereo_pkg::GRANULE_LEN,
    parameter int unsigned HINT_SHIFT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode_in,
    input  logic        ms_en_in,
    input  logic [31:0] ch1_in,
    input  logic [31:0] ch2_in,
    input  logic        gr_in,
    input  logic        din_v,
    output logic [31:0] ch1_out,
    output logic [31:0] ch2_out,
    output logic        gr_out,
    output logic        dout_v,
    output logic        ms_hint_out,
    output logic        ms_hint_v,
    output logic        gr_err
);
    import mp3_stereo_pkg::*;

    localparam int unsigned CMP_W = ACC_W + HINT_SHIFT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GRANULE_LEN - 1);

    logic [IDX_W-1:0] idx;
    logic             prev_gr;
    logic             ms_act;
    logic             abort_c;
    logic             act_c;
    logic [IDX_W-1:0] cur_idx_c;

    s1_payload_t      s1;
    logic             s1_v;

    logic signed [32:0] sum_c;
    logic signed [32:0] diff_c;
    logic signed [32:0] s2_sum;
    logic signed [32:0] s2_diff;
    q2_30_t             s2_l;
    q2_30_t             s2_r;
    logic               s2_v;
    logic               s2_gr;
    logic               s2_act;
    logic               s2_err;
    logic               s2_last;

    logic [ACC_W-1:0] mid_acc;
    logic [ACC_W-1:0] side_acc;
    logic [ACC_W-1:0] mid_base_c;
    logic [ACC_W-1:0] side_base_c;
    logic             acc_clr_c;
    logic             hint_c;

    // A granule-index change away from idx 0 aborts the granule and restarts at idx 0.
    always_comb begin
        abort_c   = (idx != '0) && (gr_in != prev_gr);
        cur_idx_c = abort_c ? '0 : idx;
        act_c     = ms_act;
        if (cur_idx_c == '0) begin
            act_c = (mode_in == MODE_JOINT) && ms_en_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            prev_gr <= 1'b0;
            ms_act  <= 1'b0;
            s1_v    <= 1'b0;
            s1      <= '0;
        end else begin
            s1_v <= din_v;
            if (din_v) begin
                s1      <= '{l: ch1_in, r: ch2_in, idx: cur_idx_c, gr: gr_in,
                             ms_act: act_c, err: abort_c};
                prev_gr <= gr_in;
                ms_act  <= act_c;
                idx     <= (cur_idx_c == LAST_IDX) ? '0 : cur_idx_c + IDX_W'(1);
            end
        end
    end

    // Accumulators restart when a granule completes or when an aborting sample arrives.
    always_comb begin
        sum_c       = 33'($signed(s1.l)) + 33'($signed(s1.r));
        diff_c      = 33'($signed(s1.l)) - 33'($signed(s1.r));
        acc_clr_c   = (s2_v && s2_last) || (s1_v && s1.err);
        mid_base_c  = acc_clr_c ? '0 : mid_acc;
        side_base_c = acc_clr_c ? '0 : side_acc;
        hint_c      = (CMP_W'(side_acc) << HINT_SHIFT) < CMP_W'(mid_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mid_acc  <= '0;
            side_acc <= '0;
            s2_v     <= 1'b0;
            s2_sum   <= '0;
            s2_diff  <= '0;
            s2_l     <= '0;
            s2_r     <= '0;
            s2_gr    <= 1'b0;
            s2_act   <= 1'b0;
            s2_err   <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s2_v <= s1_v;
            if (s1_v) begin
                mid_acc  <= mid_base_c + mag_q16(sum_c);
                side_acc <= side_base_c + mag_q16(diff_c);
                s2_sum   <= sum_c;
                s2_diff  <= diff_c;
                s2_l     <= s1.l;
                s2_r     <= s1.r;
                s2_gr    <= s1.gr;
                s2_act   <= s1.ms_act;
                s2_err   <= s1.err;
                s2_last  <= (s1.idx == LAST_IDX);
            end else begin
                mid_acc  <= mid_base_c;
                side_acc <= side_base_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_v      <= 1'b0;
            gr_out      <= 1'b0;
            gr_err      <= 1'b0;
            ms_hint_v   <= 1'b0;
            ms_hint_out <= 1'b0;
        end else begin
            dout_v    <= s2_v;
            gr_err    <= s2_v && s2_err;
            ms_hint_v <= s2_v && s2_last;
            if (s2_v) begin
                gr_out <= s2_gr;
            end
            if (s2_v && s2_last) begin
                ms_hint_out <= hint_c;
            end
        end
    end

    ms_scale_sat u_mid (
        .clk   (clk),
        .rst   (rst),
        .en    (s2_v),
        .scale (s2_act),
        .x     (s2_sum),
        .pass  (s2_l),
        .y     (ch1_out)
    );

    ms_scale_sat u_side (
        .clk   (clk),
        .rst   (rst),
        .en    (s2_v),
        .scale (s2_act),
        .x     (s2_diff),
        .pass  (s2_r),
        .y     (ch2_out)
    );

endmodule

// File: tb/tb_ms_stereo_encoder.sv
// Self-checking bench for ms_stereo_encoder: directed table, corner sequences, random run.
module tb_ms_stereo_encoder;

    localparam int unsigned LEN = 576;
    localparam longint      K   = 64'sh2d413ccc;

    logic        clk;
    logic        rst;
    logic [1:0]  mode_in;
    logic        ms_en_in;
    logic [31:0] ch1_in;
    logic [31:0] ch2_in;
    logic        gr_in;
    logic        din_v;
    logic [31:0] ch1_out;
    logic [31:0] ch2_out;
    logic        gr_out;
    logic        dout_v;
    logic        ms_hint_out;
    logic        ms_hint_v;
    logic        gr_err;

    ms_stereo_encoder #(.GRANULE_LEN(LEN), .HINT_SHIFT(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_in     (mode_in),
        .ms_en_in    (ms_en_in),
        .ch1_in      (ch1_in),
        .ch2_in      (ch2_in),
        .gr_in       (gr_in),
        .din_v       (din_v),
        .ch1_out     (ch1_out),
        .ch2_out     (ch2_out),
        .gr_out      (gr_out),
        .dout_v      (dout_v),
        .ms_hint_out (ms_hint_out),
        .ms_hint_v   (ms_hint_v),
        .gr_err      (gr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] c1;
        logic [31:0] c2;
        logic        gr;
        logic        err;
        logic        hv;
        logic        h;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic        en;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] c1;
        logic [31:0] c2;
    } tv_t;

    exp_t        q[$];
    int          m_idx;
    logic        m_prev_gr;
    logic        m_act;
    longint      m_mid;
    longint      m_side;
    logic [31:0] e_c1;
    logic [31:0] e_c2;
    logic        e_gr;
    logic        e_hint;
    int          cyc;
    int          n_vec;
    int          n_err;
    logic        g;
    tv_t         tv[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    function automatic logic [31:0] scale(input longint x);
        longint p;
        p = (x * K) >>> 30;
        if (p > 64'sd2147483647) return 32'h7fffffff;
        if (p < -64'sd2147483648) return 32'h80000000;
        return 32'(p);
    endfunction

    function automatic longint mag(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_accept(input logic [1:0] mode, input logic en,
                                input logic [31:0] l, input logic [31:0] r, input logic gr);
        exp_t   e;
        longint s;
        longint d;
        s = longint'($signed(l)) + longint'($signed(r));
        d = longint'($signed(l)) - longint'($signed(r));
        e.err = (m_idx != 0) && (gr != m_prev_gr);
        if (e.err) begin
            m_idx  = 0;
            m_mid  = 0;
            m_side = 0;
        end
        if (m_idx == 0) m_act = (mode == 2'b01) && en;
        m_mid  += mag(s) / 65536;
        m_side += mag(d) / 65536;
        e.hv = 1'b0;
        e.h  = 1'b0;
        if (m_idx == LEN - 1) begin
            e.hv   = 1'b1;
            e.h    = (m_side * 8) < m_mid;
            m_mid  = 0;
            m_side = 0;
        end
        e.c1  = m_act ? scale(s) : l;
        e.c2  = m_act ? scale(d) : r;
        e.gr  = gr;
        e.due = cyc + 3;
        q.push_back(e);
        m_prev_gr = gr;
        m_idx     = (m_idx + 1) % LEN;
    endtask

    task automatic model_reset();
        while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
        m_idx = 0; m_prev_gr = 1'b0; m_act = 1'b0; m_mid = 0; m_side = 0;
        e_c1 = '0; e_c2 = '0; e_gr = 1'b0; e_hint = 1'b0;
    endtask

    task automatic check_cycle();
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("dout_v", 32'(dout_v), 32'd1);
            chk("ch1_out", ch1_out, e.c1);
            chk("ch2_out", ch2_out, e.c2);
            chk("gr_out", 32'(gr_out), 32'(e.gr));
            chk("gr_err", 32'(gr_err), 32'(e.err));
            chk("ms_hint_v", 32'(ms_hint_v), 32'(e.hv));
            e_c1 = e.c1; e_c2 = e.c2; e_gr = e.gr;
            if (e.hv) e_hint = e.h;
        end else begin
            chk("dout_v_idle", 32'(dout_v), 32'd0);
            chk("ch1_hold", ch1_out, e_c1);
            chk("ch2_hold", ch2_out, e_c2);
            chk("gr_hold", 32'(gr_out), 32'(e_gr));
            chk("gr_err_idle", 32'(gr_err), 32'd0);
            chk("ms_hint_v_idle", 32'(ms_hint_v), 32'd0);
        end
        chk("ms_hint_out", 32'(ms_hint_out), 32'(e_hint));
    endtask

    task automatic cycle(input logic r_, input logic v, input logic [1:0] mode, input logic en,
                         input logic [31:0] l, input logic [31:0] r, input logic gr);
        rst = r_; din_v = v; mode_in = mode; ms_en_in = en;
        ch1_in = l; ch2_in = r; gr_in = gr;
        @(negedge clk);
        check_cycle();
        if (r_) model_reset();
        else if (v) model_accept(mode, en, l, r, gr);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, g);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, g);
    endtask

    task automatic run(input int n, input logic [1:0] mode, input logic en,
                       input logic [31:0] l, input logic [31:0] r);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, mode, en, l, r, g);
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; g = 1'b0;
        rst = 1'b1; din_v = 1'b0; mode_in = 2'b00; ms_en_in = 1'b0;
        ch1_in = '0; ch2_in = '0; gr_in = 1'b0;
        model_reset();

        tv[0] = '{2'b01, 1'b1, 32'h20000000, 32'h20000000, 32'h2d413ccc, 32'h00000000};
        tv[1] = '{2'b00, 1'b1, 32'h12345678, 32'hf0000000, 32'h12345678, 32'hf0000000};
        tv[2] = '{2'b01, 1'b1, 32'h7fffffff, 32'h7fffffff, 32'h7fffffff, 32'h00000000};
        tv[3] = '{2'b01, 1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h00000000};
        tv[4] = '{2'b01, 1'b0, 32'h01000000, 32'h02000000, 32'h01000000, 32'h02000000};
        tv[5] = '{2'b11, 1'b1, 32'h0abcdef0, 32'h87654321, 32'h0abcdef0, 32'h87654321};
        tv[6] = '{2'b01, 1'b1, 32'h40000000, 32'h00000000, 32'h2d413ccc, 32'h2d413ccc};
        tv[7] = '{2'b01, 1'b1, 32'h00000000, 32'h40000000, 32'h2d413ccc, 32'hd2bec334};
        tv[8] = '{2'b01, 1'b1, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000};
        tv[9] = '{2'b01, 1'b1, 32'hffffffff, 32'h00000000, 32'hffffffff, 32'hffffffff};

        @(posedge clk);
        #1;
        do_reset();
        idle();

        // Directed single-sample vectors, each starting a fresh granule.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            cycle(1'b0, 1'b1, tv[i].mode, tv[i].en, tv[i].l, tv[i].r, g);
            idle();
            idle();
            chk("tbl_dout_v", 32'(dout_v), 32'd1);
            chk("tbl_ch1", ch1_out, tv[i].c1);
            chk("tbl_ch2", ch2_out, tv[i].c2);
            idle();
        end

        // Correlated granule recommends MS, anti-correlated granule does not.
        do_reset();
        run(LEN, 2'b01, 1'b1, 32'h10000000, 32'h10000000);
        idle(); idle();
        chk("hint1_v", 32'(ms_hint_v), 32'd1);
        chk("hint1_out", 32'(ms_hint_out), 32'd1);
        g = 1'b1;
        run(LEN, 2'b01, 1'b1, 32'h10000000, 32'hf0000000);
        idle(); idle();
        chk("hint2_v", 32'(ms_hint_v), 32'd1);
        chk("hint2_out", 32'(ms_hint_out), 32'd0);
        g = 1'b0;
        run(LEN, 2'b01, 1'b1, 32'h10000000, 32'h10000000);
        idle(); idle();
        chk("hint3_out", 32'(ms_hint_out), 32'd1);

        // Reset with samples in flight.
        g = 1'b1;
        run(3, 2'b01, 1'b1, 32'h20000000, 32'h20000000);
        do_reset();
        chk("rst_dout_v", 32'(dout_v), 32'd0);
        chk("rst_ch1", ch1_out, 32'h0);
        chk("rst_ch2", ch2_out, 32'h0);
        chk("rst_gr_out", 32'(gr_out), 32'd0);
        chk("rst_hint_out", 32'(ms_hint_out), 32'd0);
        g = 1'b0;
        idle(); idle(); idle();

        // Granule abort at idx 100; the next recommendation follows one full granule later.
        do_reset();
        run(100, 2'b01, 1'b1, 32'h01000000, 32'h02000000);
        g = 1'b1;
        cycle(1'b0, 1'b1, 2'b01, 1'b1, 32'h01000000, 32'h02000000, g);
        idle(); idle();
        chk("abort_dout_v", 32'(dout_v), 32'd1);
        chk("abort_gr_err", 32'(gr_err), 32'd1);
        chk("abort_no_hint", 32'(ms_hint_v), 32'd0);
        run(LEN - 1, 2'b01, 1'b1, 32'h01000000, 32'h02000000);
        idle(); idle();
        chk("abort_hint_v", 32'(ms_hint_v), 32'd1);

        // ms_en change mid-granule takes effect only at the next idx 0.
        do_reset();
        run(10, 2'b01, 1'b1, 32'h20000000, 32'h20000000);
        cycle(1'b0, 1'b1, 2'b01, 1'b0, 32'h20000000, 32'h20000000, g);
        idle(); idle();
        chk("latch_held_ch1", ch1_out, 32'h2d413ccc);
        run(LEN - 11, 2'b01, 1'b0, 32'h20000000, 32'h20000000);
        cycle(1'b0, 1'b1, 2'b01, 1'b0, 32'h20000000, 32'h20000000, g);
        idle(); idle();
        chk("latch_next_ch1", ch1_out, 32'h20000000);

        // Random traffic with gaps, mode churn, granule toggles, rare aborts and resets.
        begin
            logic        corr;
            logic        v;
            logic [31:0] l;
            logic [31:0] r;
            corr = 1'b0;
            do_reset();
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 1999) == 0) begin
                    do_reset();
                    continue;
                end
                v = ($urandom_range(0, 99) < 75);
                if (v && m_idx == 0) begin
                    corr = $urandom_range(0, 1) == 1;
                    if ($urandom_range(0, 1) == 1) g = ~g;
                end else if (v && $urandom_range(0, 599) == 0) begin
                    g = ~g;
                end
                case ($urandom_range(0, 7))
                    0:       l = 32'h7fffffff;
                    1:       l = 32'h80000000;
                    default: l = $urandom;
                endcase
                r = corr ? (l ^ ($urandom & 32'h000000ff)) : $urandom;
                cycle(1'b0, v, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), l, r, g);
            end
            for (int i = 0; i < 5; i++) idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
